// File: rtl/axi4_burst_master_if.sv
// AXI4 channel bundle (AW/W/B/AR/R) between the burst master and a memory-mapped slave.
interface axi4_burst_master_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
);
   logic [ADDR_WIDTH-1:0] AWADDR;
   logic [7:0]            AWLEN;
   logic [2:0]            AWSIZE;
   logic                  AWVALID;
   logic                  AWREADY;

   logic [DATA_WIDTH-1:0] WDATA;
   logic                  WLAST;
   logic                  WVALID;
   logic                  WREADY;

   logic [1:0]            BRESP;
   logic                  BVALID;
   logic                  BREADY;

   logic [ADDR_WIDTH-1:0] ARADDR;
   logic [7:0]            ARLEN;
   logic [2:0]            ARSIZE;
   logic                  ARVALID;
   logic                  ARREADY;

   logic [DATA_WIDTH-1:0] RDATA;
   logic [1:0]            RRESP;
   logic                  RLAST;
   logic                  RVALID;
   logic                  RREADY;

   modport master (
      output AWADDR, AWLEN, AWSIZE, AWVALID, input AWREADY,
      output WDATA, WLAST, WVALID, input WREADY,
      input BRESP, BVALID, output BREADY,
      output ARADDR, ARLEN, ARSIZE, ARVALID, input ARREADY,
      input RDATA, RRESP, RLAST, RVALID, output RREADY
   );

   modport slave (
      input AWADDR, AWLEN, AWSIZE, AWVALID, output AWREADY,
      input WDATA, WLAST, WVALID, output WREADY,
      output BRESP, BVALID, input BREADY,
      input ARADDR, ARLEN, ARSIZE, ARVALID, output ARREADY,
      output RDATA, RRESP, RLAST, RVALID, input RREADY
   );
endinterface

// File: rtl/axi4_burst_master.sv
// Single-outstanding AXI4 INCR burst initiator: one write or read burst per local command.
// Define BOUNDARY_CHECK_EN to reject bursts that would cross a 4 KB page without touching the bus.
module axi4_burst_master #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  ACLK,
   input  logic                  ARESET,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [7:0]            cmd_len,
   input  logic [2:0]            cmd_size,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_valid,
   output logic                  wr_ready,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  rd_valid,
   output logic                  rd_last,
   output logic                  done,
   output logic [1:0]            resp,
   axi4_burst_master_if.master   bus
);
   typedef enum logic [2:0] {IDLE, AW, W, B, AR, R} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [7:0]            len_q;
   logic [2:0]            size_q;
   logic [8:0]            beat_cnt;
   logic                  err;
   logic                  aw_valid_q;
   logic                  ar_valid_q;
   logic                  b_ready_q;
   logic                  r_ready_q;
   logic                  in_w;
   logic                  cross_4k;

`ifdef BOUNDARY_CHECK_EN
   // 17 bits so that len=255 with a large size still compares correctly.
   logic [16:0] span_end;
   assign span_end = {5'b0, cmd_addr[11:0]} + ({8'b0, ({1'b0, cmd_len} + 9'd1)} << cmd_size);
   assign cross_4k = (span_end > 17'd4096);
`else
   assign cross_4k = 1'b0;
`endif

   // W channel is a straight pass-through while a write burst is streaming.
   assign in_w       = (state == W);
   assign bus.WVALID = in_w & wr_valid;
   assign bus.WDATA  = in_w ? wr_data : '0;
   assign bus.WLAST  = in_w & (beat_cnt == {1'b0, len_q});
   assign wr_ready   = in_w & bus.WREADY;

   assign bus.AWADDR  = addr_q;
   assign bus.AWLEN   = len_q;
   assign bus.AWSIZE  = size_q;
   assign bus.AWVALID = aw_valid_q;
   assign bus.BREADY  = b_ready_q;
   assign bus.ARADDR  = addr_q;
   assign bus.ARLEN   = len_q;
   assign bus.ARSIZE  = size_q;
   assign bus.ARVALID = ar_valid_q;
   assign bus.RREADY  = r_ready_q;

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state      <= IDLE;
         cmd_ready  <= 1'b0;
         addr_q     <= '0;
         len_q      <= '0;
         size_q     <= '0;
         beat_cnt   <= '0;
         err        <= 1'b0;
         aw_valid_q <= 1'b0;
         ar_valid_q <= 1'b0;
         b_ready_q  <= 1'b0;
         r_ready_q  <= 1'b0;
         rd_data    <= '0;
         rd_valid   <= 1'b0;
         rd_last    <= 1'b0;
         done       <= 1'b0;
         resp       <= '0;
      end else begin
         done     <= 1'b0;
         rd_valid <= 1'b0;
         rd_last  <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_ready && cmd_valid) begin
                  cmd_ready <= 1'b0;
                  addr_q    <= cmd_addr;
                  len_q     <= cmd_len;
                  size_q    <= cmd_size;
                  beat_cnt  <= '0;
                  err       <= 1'b0;
                  if (cross_4k) begin
                     done <= 1'b1;
                     resp <= 2'b10;
                  end else if (cmd_write) begin
                     state      <= AW;
                     aw_valid_q <= 1'b1;
                  end else begin
                     state      <= AR;
                     ar_valid_q <= 1'b1;
                  end
               end else begin
                  // Also gives the one idle cycle between done and the next accept.
                  cmd_ready <= 1'b1;
               end
            end
            AW: begin
               if (bus.AWREADY) begin
                  aw_valid_q <= 1'b0;
                  state      <= W;
               end
            end
            W: begin
               if (bus.WVALID && bus.WREADY) begin
                  beat_cnt <= beat_cnt + 9'd1;
                  if (bus.WLAST) begin
                     state     <= B;
                     b_ready_q <= 1'b1;
                  end
               end
            end
            B: begin
               if (bus.BVALID) begin
                  resp      <= bus.BRESP;
                  done      <= 1'b1;
                  b_ready_q <= 1'b0;
                  state     <= IDLE;
               end
            end
            AR: begin
               if (bus.ARREADY) begin
                  ar_valid_q <= 1'b0;
                  r_ready_q  <= 1'b1;
                  state      <= R;
               end
            end
            R: begin
               if (bus.RVALID) begin
                  rd_data  <= bus.RDATA;
                  rd_valid <= 1'b1;
                  rd_last  <= bus.RLAST;
                  beat_cnt <= beat_cnt + 9'd1;
                  if (bus.RLAST) begin
                     resp      <= (err | bus.RRESP[1] | (beat_cnt != {1'b0, len_q})) ? 2'b10 : 2'b00;
                     done      <= 1'b1;
                     r_ready_q <= 1'b0;
                     state     <= IDLE;
                  end else begin
                     // Reaching or passing the final beat without RLAST is a protocol error.
                     err <= err | bus.RRESP[1] | (beat_cnt >= {1'b0, len_q});
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_axi4_burst_master.sv
// Bench for axi4_burst_master: 1024-word slave, command-level reference model, per-cycle compare.
module tb_axi4_burst_master;
   logic        ACLK = 1'b0;
   logic        ARESET;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [15:0] cmd_addr;
   logic [7:0]  cmd_len;
   logic [2:0]  cmd_size;
   logic [31:0] wr_data;
   logic        wr_valid, wr_ready;
   logic [31:0] rd_data;
   logic        rd_valid, rd_last, done;
   logic [1:0]  resp;

   axi4_burst_master_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();

   axi4_burst_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
      .ACLK(ACLK), .ARESET(ARESET),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_size(cmd_size),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
      .done(done), .resp(resp), .bus(bus)
   );

   initial forever #5 ACLK = ~ACLK;

   int checks = 0;
   int errors = 0;

   // reference model: what the current command must produce
   bit          in_cmd, exp_write, exp_issue;
   logic [15:0] exp_addr;
   logic [7:0]  exp_len;
   logic [2:0]  exp_size;
   logic [1:0]  exp_resp;
   logic [31:0] exp_w [256];
   logic [31:0] exp_r [256];
   logic [31:0] ref_mem [1024];
   int          rd_last_idx;

   // slave and observation state
   logic [31:0] mem [1024];
   logic [31:0] rd_log [256];
   int aw_hs, ar_hs, w_hs, b_hs, wsrc, r_beat, r_total, aw_wait, cyc, rd_idx, done_cnt, awv_cyc;
   bit r_active, b_pending, w_err, wr_en;
   int aw_delay;
   bit r_gap, r_short, wr_gap, wready_stall;
   logic [15:0] s_addr;
   logic [2:0]  s_size;
   logic [1:0]  last_resp;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, expv, $time);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_cmd_ready"}, cmd_ready, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_resp"}, resp, 0);
      check({tag, "_rd_valid"}, rd_valid, 0);
      check({tag, "_rd_last"}, rd_last, 0);
      check({tag, "_rd_data"}, rd_data, 0);
      check({tag, "_wr_ready"}, wr_ready, 0);
      check({tag, "_awvalid"}, bus.AWVALID, 0);
      check({tag, "_awaddr"}, bus.AWADDR, 0);
      check({tag, "_wvalid"}, bus.WVALID, 0);
      check({tag, "_wdata"}, bus.WDATA, 0);
      check({tag, "_bready"}, bus.BREADY, 0);
      check({tag, "_arvalid"}, bus.ARVALID, 0);
      check({tag, "_rready"}, bus.RREADY, 0);
   endtask

   // slave: record handshakes at the edge, drive responses on the falling edge
   initial begin
      int a;
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      {bus.AWREADY, bus.WREADY, bus.BVALID, bus.ARREADY, bus.RVALID, bus.RLAST} = '0;
      bus.BRESP = '0; bus.RRESP = '0; bus.RDATA = '0;
      wr_valid = 1'b0; wr_data = '0;
      forever begin
         @(posedge ACLK);
         if (ARESET) begin
            r_active = 0; b_pending = 0; w_err = 0;
         end else begin
            if (bus.AWVALID && bus.AWREADY) begin
               aw_hs++; s_addr = bus.AWADDR; s_size = bus.AWSIZE;
            end
            if (bus.WVALID && bus.WREADY) begin
               a = int'(s_addr) + (w_hs << s_size);
               if (a >= 4096) w_err = 1; else mem[a >> 2] = bus.WDATA;
               w_hs++;
               if (bus.WLAST) b_pending = 1;
            end
            if (wr_valid && wr_ready) wsrc++;
            if (bus.BVALID && bus.BREADY) begin b_pending = 0; w_err = 0; b_hs++; end
            if (bus.RVALID && bus.RREADY) begin
               r_beat++;
               if (r_beat == r_total) r_active = 0;
            end
            if (bus.ARVALID && bus.ARREADY) begin
               ar_hs++; s_addr = bus.ARADDR; s_size = bus.ARSIZE; r_beat = 0;
               r_total = r_short ? int'(bus.ARLEN) : int'(bus.ARLEN) + 1;
               r_active = 1;
            end
         end
         @(negedge ACLK);
         cyc++;
         if (bus.AWVALID && aw_wait < aw_delay) begin
            bus.AWREADY = 1'b0; aw_wait++;
         end else begin
            bus.AWREADY = bus.AWVALID;
            if (!bus.AWVALID) aw_wait = 0;
         end
         bus.ARREADY = bus.ARVALID;
         bus.WREADY  = !(wready_stall && (cyc % 3 == 0));
         bus.BVALID  = b_pending;
         bus.BRESP   = w_err ? 2'b10 : 2'b00;
         if (r_active && !(r_gap && (cyc % 2 == 1))) begin
            a = int'(s_addr) + (r_beat << s_size);
            bus.RVALID = 1'b1;
            bus.RLAST  = (r_beat == r_total - 1);
            if (a >= 4096) begin bus.RDATA = '0; bus.RRESP = 2'b10; end
            else begin bus.RDATA = mem[a >> 2]; bus.RRESP = 2'b00; end
         end else begin
            bus.RVALID = 1'b0; bus.RLAST = 1'b0;
         end
         wr_valid = wr_en && (wsrc <= int'(exp_len)) && !(wr_gap && (cyc % 4 == 1));
         wr_data  = (wsrc < 256) ? exp_w[wsrc] : '0;
      end
   end

   // per-cycle compare against the command-level model
   initial begin
      bit w_win;
      forever begin
         @(negedge ACLK);
         #2;
         if (!ARESET) begin
            if (done) begin
               done_cnt++;
               last_resp = resp;
               check("done_resp", resp, exp_resp);
               check("done_cmd_ready_overlap", cmd_ready, 0);
            end
            if (bus.AWVALID) awv_cyc++;
            check("awvalid", bus.AWVALID, in_cmd && exp_issue && exp_write && aw_hs == 0);
            check("arvalid", bus.ARVALID, in_cmd && exp_issue && !exp_write && ar_hs == 0);
            if (bus.AWVALID) begin
               check("awaddr", bus.AWADDR, exp_addr);
               check("awlen", bus.AWLEN, exp_len);
               check("awsize", bus.AWSIZE, exp_size);
            end
            if (bus.ARVALID) begin
               check("araddr", bus.ARADDR, exp_addr);
               check("arlen", bus.ARLEN, exp_len);
               check("arsize", bus.ARSIZE, exp_size);
            end
            w_win = in_cmd && exp_issue && exp_write && aw_hs == 1 && w_hs <= int'(exp_len);
            check("wvalid", bus.WVALID, w_win && wr_valid);
            check("wr_ready", wr_ready, w_win && bus.WREADY);
            if (bus.WVALID) begin
               check("wdata", bus.WDATA, exp_w[w_hs]);
               check("wlast", bus.WLAST, w_hs == int'(exp_len));
            end
            check("bready", bus.BREADY,
                  in_cmd && exp_issue && exp_write && w_hs == int'(exp_len) + 1 && b_hs == 0);
            check("rready", bus.RREADY,
                  in_cmd && exp_issue && !exp_write && ar_hs == 1 && r_beat < r_total);
            if (rd_valid && rd_idx < 256) begin
               rd_log[rd_idx] = rd_data;
               check("rd_data", rd_data, exp_r[rd_idx]);
               check("rd_last", rd_last, rd_idx == rd_last_idx);
               rd_idx++;
            end
         end
      end
   end

   task automatic setup(input bit wr, input logic [15:0] a, input logic [7:0] l,
                        input logic [2:0] s, input logic [31:0] base);
      int step, ad;
      step = 1 << s;
      exp_write = wr; exp_addr = a; exp_len = l; exp_size = s;
      exp_issue = 1;
`ifdef BOUNDARY_CHECK_EN
      if (int'(a[11:0]) + (int'(l) + 1) * step > 4096) exp_issue = 0;
`endif
      exp_resp = 2'b00;
      for (int i = 0; i <= int'(l); i++) begin
         ad = int'(a) + i * step;
         exp_w[i] = base + i;
         if (ad >= 4096) begin exp_resp = 2'b10; exp_r[i] = '0; end
         else exp_r[i] = ref_mem[ad >> 2];
      end
      if (!wr && r_short) exp_resp = 2'b10;
      if (!exp_issue) exp_resp = 2'b10;
      rd_last_idx = r_short ? int'(l) - 1 : int'(l);
      aw_hs = 0; ar_hs = 0; w_hs = 0; b_hs = 0; wsrc = 0; rd_idx = 0; awv_cyc = 0; r_total = 0; r_beat = 0;
   endtask

   task automatic accept(input bit wr, output bit acc);
      @(negedge ACLK);
      cmd_valid = 1'b1; cmd_write = wr; cmd_addr = exp_addr; cmd_len = exp_len; cmd_size = exp_size;
      wr_en = wr;
      acc = 0;
      for (int c = 0; c < 50 && !acc; c++) begin
         @(posedge ACLK);
         acc = cmd_ready;
      end
      in_cmd = acc;
      @(negedge ACLK);
      cmd_valid = 1'b0;
      check("cmd_accept", acc, 1);
   endtask

   task automatic run_cmd(input bit wr, input logic [15:0] a, input logic [7:0] l,
                          input logic [2:0] s, input logic [31:0] base);
      bit acc;
      int d0, ad;
      setup(wr, a, l, s, base);
      d0 = done_cnt;
      accept(wr, acc);
`ifdef BOUNDARY_CHECK_EN
      #3;
      if (!exp_issue) check("reject_done_next_cycle", done, 1);
`endif
      for (int c = 0; c < 1000 && done_cnt == d0; c++) @(posedge ACLK);
      @(negedge ACLK);
      #3;
      check("done_count", done_cnt - d0, 1);
      if (exp_issue && wr) begin
         check("aw_handshakes", aw_hs, 1);
         check("w_beats", w_hs, int'(l) + 1);
      end else if (exp_issue) begin
         check("ar_handshakes", ar_hs, 1);
         check("rd_beats", rd_idx, rd_last_idx + 1);
      end else begin
         check("no_aw_traffic", aw_hs + ar_hs + w_hs, 0);
      end
      if (wr && exp_issue)
         for (int i = 0; i <= int'(l); i++) begin
            ad = int'(a) + (i << s);
            if (ad < 4096) ref_mem[ad >> 2] = exp_w[i];
         end
      in_cmd = 0; wr_en = 0;
   endtask

   initial begin
      bit acc;
      int d0;
      for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
      ARESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0;
      in_cmd = 0; wr_en = 0; aw_delay = 0; r_gap = 0; r_short = 0; wr_gap = 0; wready_stall = 0;
      exp_len = '0;
      repeat (3) @(negedge ACLK);
      #1 check_idle("reset");
      @(negedge ACLK);
      ARESET = 1'b0;
      #1 check("cmd_ready_at_release", cmd_ready, 0);
      @(negedge ACLK);
      #1 check("cmd_ready_after_release", cmd_ready, 1);

      // 1: write A0..A3 to 0x10 with source gaps and slave stalls
      wr_gap = 1; wready_stall = 1;
      run_cmd(1, 16'h0010, 8'd3, 3'd2, 32'hA0);
      wr_gap = 0; wready_stall = 0;
      check("t1_resp", last_resp, 2'b00);
      check("t1_mem4", mem[4], 32'hA0);
      check("t1_mem7", mem[7], 32'hA3);

      // 2: read it back with gaps in RVALID
      r_gap = 1;
      run_cmd(0, 16'h0010, 8'd3, 3'd2, 32'h0);
      r_gap = 0;
      check("t2_resp", last_resp, 2'b00);
      check("t2_rd0", rd_log[0], 32'hA0);
      check("t2_rd3", rd_log[3], 32'hA3);

      // 3: outside the 1024-word slave
      run_cmd(1, 16'h1000, 8'd3, 3'd2, 32'hB0);
      check("t3_wr_resp", last_resp, 2'b10);
      run_cmd(0, 16'h1000, 8'd3, 3'd2, 32'h0);
      check("t3_rd_resp", last_resp, 2'b10);
      check("t3_rd_count", rd_idx, 4);
      check("t3_rd2", rd_log[2], 32'h0);

      // 4: AWREADY held low for 5 cycles
      aw_delay = 5;
      run_cmd(1, 16'h0040, 8'd1, 3'd2, 32'hC0);
      aw_delay = 0;
      check("t4_awvalid_cycles", awv_cyc, 6);
      check("t4_resp", last_resp, 2'b00);

      // early RLAST from the slave
      r_short = 1;
      run_cmd(0, 16'h0010, 8'd3, 3'd2, 32'h0);
      r_short = 0;
      check("short_rlast_resp", last_resp, 2'b10);

      // single-beat write and read
      run_cmd(1, 16'h0080, 8'd0, 3'd2, 32'hD0);
      run_cmd(0, 16'h0080, 8'd0, 3'd2, 32'h0);
      check("len0_rd", rd_log[0], 32'hD0);

      // 6: 4 KB boundary: ending exactly at 4096 is fine, past it is not
      run_cmd(1, 16'h0FF0, 8'd3, 3'd2, 32'hF0);
      check("t6_exact_resp", last_resp, 2'b00);
      run_cmd(1, 16'h0FF8, 8'd3, 3'd2, 32'hE0);
      check("t6_cross_resp", last_resp, 2'b10);
`ifdef BOUNDARY_CHECK_EN
      check("t6_no_aw", awv_cyc, 0);
`else
      check("t6_issued_aw", awv_cyc, 1);
`endif

      // 5: reset after the 2nd W beat of a len-7 burst
      setup(1, 16'h0200, 8'd7, 3'd2, 32'h50);
      d0 = done_cnt;
      accept(1, acc);
      for (int c = 0; c < 100 && w_hs < 2; c++) @(posedge ACLK);
      check("t5_two_beats", w_hs, 2);
      @(negedge ACLK);
      ARESET = 1'b1;
      in_cmd = 0; wr_en = 0;
      #1 check_idle("abort");
      repeat (2) @(negedge ACLK);
      ARESET = 1'b0;
      #1 check("t5_cmd_ready_at_release", cmd_ready, 0);
      @(negedge ACLK);
      #1 check("t5_cmd_ready_after_release", cmd_ready, 1);
      check("t5_no_done", done_cnt - d0, 0);
      ref_mem[32'h200 >> 2] = 32'h50;
      ref_mem[(32'h200 >> 2) + 1] = 32'h51;

      // recovery after abort
      run_cmd(0, 16'h0010, 8'd3, 3'd2, 32'h0);
      check("recover_rd3", rd_log[3], 32'hA3);
      run_cmd(0, 16'h0200, 8'd1, 3'd2, 32'h0);
      check("abort_partial_rd1", rd_log[1], 32'h51);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end
endmodule
